i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h33: 7-bit address this target answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on SDA/SCL inputs.
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_sda  input  1  sampled SDA line level.
REQ-006 SHALL have port i_scl  input  1  sampled SCL line level.
REQ-007 SHALL have port o_sda_drive  output  1  SDA drive value: 0 = pull low, 1 = release.
REQ-008 SHALL have port o_scl_drive  output  1  SCL drive value: 0 = stretch (hold low), 1 = release.
REQ-009 SHALL have port o_start  output  1  one-cycle pulse on START or repeated START.
REQ-010 SHALL have port o_stop  output  1  one-cycle pulse on STOP.
REQ-011 SHALL have port o_rx_valid  output  1  one-cycle pulse: o_rx_data holds a received data byte.
REQ-012 SHALL have port o_rx_data  output  8  last received data byte; held until the next byte.
REQ-013 SHALL have port o_rx_first  output  1  qualifies o_rx_valid: first data byte after address.
REQ-014 SHALL have port o_tx_ready  output  1  target requests a read byte; SCL is stretched.
REQ-015 SHALL have port i_tx_valid  input  1  user offers i_tx_data; accepted when valid & ready.
REQ-016 SHALL have port i_tx_data  input  8  byte to return to the master, MSB first.

Function
REQ-017 SHALL synchronise SDA and SCL through SYNC_STAGES flops, then detect SCL rise/fall, START (SDA fall while SCL high) and STOP (SDA rise while SCL high) one cycle later.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE.
REQ-019 SHALL, on START in any state, pulse o_start, release SDA and SCL, clear the bit counter, and enter ADDR.
REQ-020 SHALL, on STOP in any state, pulse o_stop, release SDA and SCL, and enter IDLE; STOP takes priority over SCL edges in the same cycle.
REQ-021 SHALL shift SDA into an 8-bit register MSB first on each SCL rise in ADDR and RX_BYTE; the counter wraps 7->0.
REQ-022 SHALL, after the 8th address bit, compare bits [7:1] with TARGET_ADDR; on the next SCL fall go to ADDR_ACK and drive SDA 0 on match, otherwise go to IGNORE with SDA released.
REQ-023 SHALL, in ADDR_ACK on SCL fall, release SDA and go to RX_BYTE if R/W=0, or to TX_LOAD if R/W=1.
REQ-024 SHALL, after the 8th RX bit rise, pulse o_rx_valid with o_rx_data updated in the same cycle, and set o_rx_first=1 only for the first byte since the address.
REQ-025 SHALL, in RX_BYTE on the following SCL fall, drive SDA 0 (always ACK) and enter RX_ACK; in RX_ACK on SCL fall, release SDA and return to RX_BYTE.
REQ-026 SHALL, in TX_LOAD, hold o_scl_drive=0 and o_tx_ready=1; on the valid & ready handshake, load i_tx_data and drive bit 7 on SDA that cycle; release SCL the next cycle and enter TX_BYTE.
REQ-027 SHALL, in TX_BYTE, present the next bit on each SCL fall; after the 8th bit's fall, release SDA and enter TX_ACK.
REQ-028 SHALL, in TX_ACK, sample SDA on SCL rise: 0 (ACK) -> TX_LOAD on the next fall; 1 (NACK) -> IGNORE.
REQ-029 SHALL, in IGNORE and IDLE, keep SDA/SCL released and react only to START/STOP.
REQ-030 SHALL never pull SCL low except in TX_LOAD.

Reset
REQ-031 SHALL, while i_rst=1, force: state IDLE; o_sda_drive=1; o_scl_drive=1; o_start, o_stop, o_rx_valid, o_rx_first, o_tx_ready=0; o_rx_data=8'h00; counter=0; synchronisers=1.
REQ-032 SHALL, on reset mid-transfer, release both lines immediately and ignore the bus until the next START.

Structure
REQ-033 SHALL place the state enum and the I2C address width constant in shared package i2c_pkg.
REQ-034 SHALL instantiate one sub-module i2c_line_sync per line (synchroniser plus rise/fall detect).
REQ-035 SHALL keep all next-state logic in a single combinational block over a registered control struct.

Verification
REQ-036 SHALL test a write: START, 0x66, 0xA5, 0x3C, STOP -> ACK on address and both data bytes; o_rx_valid twice with 0xA5 (first=1), then 0x3C (first=0); o_start once, o_stop once.
REQ-037 SHALL test an address mismatch: START, 0x44, 0x11, STOP -> SDA never driven 0, no o_rx_valid, state IDLE after STOP.
REQ-038 SHALL test a read with stretching: START, 0x67, user delays i_tx_valid 50 cycles with 0xC3, master ACKs, then offers 0x5A, master NACKs -> SCL held low during both waits; master reads 0xC3 then 0x5A; then IGNORE.
REQ-039 SHALL test a repeated START: write 0x66, 0x01, repeated START, 0x67 -> o_start pulses twice and the target enters TX_LOAD.
REQ-040 SHALL test a STOP mid-byte after 4 data bits -> o_stop, IDLE, no o_rx_valid, lines released.
REQ-041 SHALL test reset asserted during TX_LOAD -> o_scl_drive=1 and o_sda_drive=1 the next cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C target types: address width, FSM state codes and the registered control record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int ADDR_W = 7;

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_RX_BYTE  = 4'd3;
  localparam logic [3:0] ST_RX_ACK   = 4'd4;
  localparam logic [3:0] ST_TX_LOAD  = 4'd5;
  localparam logic [3:0] ST_TX_BYTE  = 4'd6;
  localparam logic [3:0] ST_TX_ACK   = 4'd7;
  localparam logic [3:0] ST_IGNORE   = 4'd8;

  // Everything the FSM remembers between cycles; outputs come straight from here.
  typedef struct packed {
    state_t     state;
    logic [2:0] bit_cnt;     // bit index within the current byte, wraps 7->0
    logic [7:0] shreg;       // address/RX shift-in, TX shift-out
    logic       byte_done;   // 8th bit seen, waiting for the SCL fall that ends it
    logic       first_pend;  // next RX byte is the first after the address
    logic       rw;          // R/W bit of the matched address byte
    logic       tx_loaded;   // TX byte accepted, SCL release due next cycle
    logic       tx_acked;    // master ACKed the last TX byte
    logic       sda_drive;   // 0 = pull low, 1 = release
    logic       scl_drive;   // 0 = stretch, 1 = release
    logic       start;
    logic       stop;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] rx_data;
  } ctrl_t;

  // Idle bus, both lines released, no pulses.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c           = '0;
    c.state     = ST_IDLE;
    c.sda_drive = 1'b1;
    c.scl_drive = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises one open-drain bus line into core_clk and flags its rising/falling edges.
// Latency: STAGES cycles to level, edges flagged in the cycle the synchronised level changes.
// Backpressure: none, free-running.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain and previous-level flop; reset to the idle (high) bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(line);
      prev_q <= level;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write bytes out to the user, read bytes in from the user with SCL stretching.
// Latency: bus edges act SYNC_STAGES+1 cycles after they reach the pins; outputs are registered.
// Backpressure: SCL is held low in TX_LOAD until the user offers a byte (i_tx_valid & o_tx_ready).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h33,
  parameter int                SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic       o_scl_drive,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_first,
  output logic       o_tx_ready,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data
);

  logic sda_lvl, sda_rise, sda_fall;
  logic scl_lvl, scl_rise, scl_fall;
  logic start_cond, stop_cond;

  ctrl_t cur, nxt;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .line  (i_sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .line  (i_scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  // SDA moving while SCL is high is a bus condition, never data.
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  // All next-state decisions; STOP beats START beats any SCL edge.
  always_comb begin
    nxt          = cur;
    nxt.start    = 1'b0;
    nxt.stop     = 1'b0;
    nxt.rx_valid = 1'b0;
    nxt.rx_first = 1'b0;

    if (stop_cond) begin
      nxt.stop      = 1'b1;
      nxt.sda_drive = 1'b1;
      nxt.scl_drive = 1'b1;
      nxt.byte_done = 1'b0;
      nxt.state     = ST_IDLE;
    end else if (start_cond) begin
      nxt.start     = 1'b1;
      nxt.sda_drive = 1'b1;
      nxt.scl_drive = 1'b1;
      nxt.bit_cnt   = 3'd0;
      nxt.byte_done = 1'b0;
      nxt.state     = ST_ADDR;
    end else begin
      case (cur.state)
        ST_ADDR: begin
          if (scl_rise) begin
            nxt.shreg   = {cur.shreg[6:0], sda_lvl};
            nxt.bit_cnt = cur.bit_cnt + 3'd1;
            if (cur.bit_cnt == 3'd7) nxt.byte_done = 1'b1;
          end else if (scl_fall && cur.byte_done) begin
            nxt.byte_done = 1'b0;
            if (cur.shreg[7:1] == TARGET_ADDR) begin
              nxt.state     = ST_ADDR_ACK;
              nxt.sda_drive = 1'b0;
              nxt.rw        = cur.shreg[0];
            end else begin
              nxt.state     = ST_IGNORE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            nxt.sda_drive = 1'b1;
            nxt.bit_cnt   = 3'd0;
            if (cur.rw) begin
              // Grab SCL while the master has it low so it cannot clock before data is ready.
              nxt.state     = ST_TX_LOAD;
              nxt.scl_drive = 1'b0;
              nxt.tx_loaded = 1'b0;
            end else begin
              nxt.state      = ST_RX_BYTE;
              nxt.first_pend = 1'b1;
            end
          end
        end

        ST_RX_BYTE: begin
          if (scl_rise) begin
            nxt.shreg   = {cur.shreg[6:0], sda_lvl};
            nxt.bit_cnt = cur.bit_cnt + 3'd1;
            if (cur.bit_cnt == 3'd7) begin
              nxt.byte_done  = 1'b1;
              nxt.rx_valid   = 1'b1;
              nxt.rx_data    = {cur.shreg[6:0], sda_lvl};
              nxt.rx_first   = cur.first_pend;
              nxt.first_pend = 1'b0;
            end
          end else if (scl_fall && cur.byte_done) begin
            nxt.byte_done = 1'b0;
            nxt.sda_drive = 1'b0;
            nxt.state     = ST_RX_ACK;
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            nxt.sda_drive = 1'b1;
            nxt.state     = ST_RX_BYTE;
          end
        end

        ST_TX_LOAD: begin
          // Bit 7 goes on SDA one cycle before SCL is let go, giving it setup time.
          if (cur.tx_loaded) begin
            nxt.scl_drive = 1'b1;
            nxt.bit_cnt   = 3'd0;
            nxt.state     = ST_TX_BYTE;
          end else if (i_tx_valid) begin
            nxt.shreg     = i_tx_data;
            nxt.sda_drive = i_tx_data[7];
            nxt.tx_loaded = 1'b1;
          end
        end

        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (cur.bit_cnt == 3'd7) begin
              nxt.sda_drive = 1'b1;
              nxt.bit_cnt   = 3'd0;
              nxt.tx_acked  = 1'b0;
              nxt.state     = ST_TX_ACK;
            end else begin
              nxt.shreg     = {cur.shreg[6:0], 1'b0};
              nxt.sda_drive = cur.shreg[6];
              nxt.bit_cnt   = cur.bit_cnt + 3'd1;
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) nxt.state    = ST_IGNORE;
            else         nxt.tx_acked = 1'b1;
          end else if (scl_fall && cur.tx_acked) begin
            nxt.state     = ST_TX_LOAD;
            nxt.scl_drive = 1'b0;
            nxt.tx_loaded = 1'b0;
          end
        end

        default: begin
          // IDLE and IGNORE: hands off the bus, only START/STOP matter.
          nxt.sda_drive = 1'b1;
          nxt.scl_drive = 1'b1;
        end
      endcase
    end
  end

  // Control register; reset drops both lines on the very next edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) cur <= ctrl_reset();
    else       cur <= nxt;
  end

  assign o_sda_drive = cur.sda_drive;
  assign o_scl_drive = cur.scl_drive;
  assign o_start     = cur.start;
  assign o_stop      = cur.stop;
  assign o_rx_valid  = cur.rx_valid;
  assign o_rx_data   = cur.rx_data;
  assign o_rx_first  = cur.rx_first;
  assign o_tx_ready  = (cur.state == ST_TX_LOAD) && !cur.tx_loaded;

endmodule
